// File: rtl/rf_bank_port_arbiter.sv
// rf_bank_port_arbiter: arbitrates writeback writes and tagged operand reads onto one
// single-port write-first BRAM, tracking its 1-cycle latency into a 2-entry response buffer.
// Ports: clk/rst_n (async low); wb_* write request; rd_* tagged read request;
// rsp_* response head with backpressure; bram_* to/from the BRAM port.
// Option: RF_BANK_BYPASS_EN grants a same-address write and read together in one cycle.
module rf_bank_port_arbiter #(
  parameter int ADDR_WIDTH   = 3,
  parameter int DATA_WIDTH   = 32,
  parameter int TAG_WIDTH    = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [TAG_WIDTH-1:0]  rd_tag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0]         starve_cnt;
  logic                  inflight;
  logic [TAG_WIDTH-1:0]  inflight_tag;
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [TAG_WIDTH-1:0]  buf_tag [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            buf_count;

  logic credit;
  logic starved;
  logic same;
  logic rd_gnt;
  logic wr_gnt;
  logic buf_empty;
  logic pop;
  logic buf_pop;
  logic push;

  // Buffered plus in-flight responses must fit in the 2 buffer slots.
  assign credit  = (buf_count == 2'd0)
                 | ((buf_count == 2'd1) & ~inflight);
  assign starved = (starve_cnt == SW'(STARVE_LIMIT));

`ifdef RF_BANK_BYPASS_EN
  assign same = wb_valid & rd_valid & (wb_addr == rd_addr);
`else
  assign same = 1'b0;
`endif

  assign rd_gnt = rst_n & rd_valid & credit
                & (~wb_valid | starved | same);
  assign wr_gnt = rst_n & wb_valid & (~rd_gnt | same);

  assign wb_ready  = wr_gnt;
  assign rd_ready  = rd_gnt;
  assign bram_we   = wr_gnt;
  assign bram_addr = (wr_gnt & ~rd_gnt) ? wb_addr : rd_addr;
  assign bram_din  = wb_data;

  // An empty buffer lets the BRAM output fall straight through to rsp_*.
  assign buf_empty = (buf_count == 2'd0);
  assign rsp_valid = ~buf_empty | inflight;
  assign rsp_data  = buf_empty ? bram_dout : buf_data[rd_ptr];
  assign rsp_tag   = buf_empty ? inflight_tag : buf_tag[rd_ptr];

  assign pop     = rsp_valid & rsp_ready;
  assign buf_pop = pop & ~buf_empty;
  assign push    = inflight & ~(pop & buf_empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!rd_valid || rd_gnt) begin
      starve_cnt <= '0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight     <= 1'b0;
      inflight_tag <= '0;
    end else begin
      inflight <= rd_gnt;
      if (rd_gnt) inflight_tag <= rd_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      buf_count <= 2'd0;
    end else begin
      if (push)    wr_ptr <= ~wr_ptr;
      if (buf_pop) rd_ptr <= ~rd_ptr;
      buf_count <= buf_count + {1'b0, push}
                 - {1'b0, buf_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= bram_dout;
      buf_tag[wr_ptr]  <= inflight_tag;
    end
  end

endmodule

// File: tb/tb_rf_bank_port_arbiter.sv
// tb_rf_bank_port_arbiter: directed bench with a write-first BRAM model and
// a response scoreboard popped by a separate monitor on rsp handshakes.
module tb_rf_bank_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic        wb_ready;
  logic [2:0]  wb_addr;
  logic [31:0] wb_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [2:0]  rd_addr;
  logic [3:0]  rd_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        bram_we;
  logic [2:0]  bram_addr;
  logic [31:0] bram_din;
  logic [31:0] bram_dout;

  logic [31:0] mem [8];
  logic [35:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_bank_port_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_addr   (rd_addr),
    .rd_tag    (rd_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .bram_dout (bram_dout)
  );

  // Single-port, output-registered, write-first BRAM.
  always @(posedge clk) begin
    if (bram_we) begin
      mem[bram_addr] <= bram_din;
      bram_dout      <= bram_din;
    end else begin
      bram_dout <= mem[bram_addr];
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted response must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected got=%h/%h", rsp_data, rsp_tag);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        if ({rsp_data, rsp_tag} !== e) begin
          errors++;
          $display("FAIL rsp_data_tag got=%h/%h want=%h/%h",
                   rsp_data, rsp_tag, e[35:4], e[3:0]);
        end
      end
    end
  end

  task automatic step(input logic wv, input logic [2:0] wa,
                      input logic [31:0] wd, input logic rv,
                      input logic [2:0] ra, input logic [3:0] rt,
                      input logic rr, input logic ew,
                      input logic er, input string nm);
    @(posedge clk);
    #1;
    wb_valid  = wv;
    wb_addr   = wa;
    wb_data   = wd;
    rd_valid  = rv;
    rd_addr   = ra;
    rd_tag    = rt;
    rsp_ready = rr;
    @(negedge clk);
    chk({nm, "_wb_ready"}, {31'd0, wb_ready}, {31'd0, ew});
    chk({nm, "_rd_ready"}, {31'd0, rd_ready}, {31'd0, er});
  endtask

  task automatic idle(input string nm);
    step(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0, nm);
  endtask

  logic [31:0] exp5 [8];

  initial begin
    rst_n     = 1'b0;
    wb_valid  = 1'b1;
    wb_addr   = 3'd0;
    wb_data   = 32'd0;
    rd_valid  = 1'b1;
    rd_addr   = 3'd0;
    rd_tag    = 4'd0;
    rsp_ready = 1'b0;
    #2;
    chk("rst_wb_ready", {31'd0, wb_ready}, 32'd0);
    chk("rst_rd_ready", {31'd0, rd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    #10;
    wb_valid = 1'b0;
    rd_valid = 1'b0;
    rst_n    = 1'b1;

    for (int i = 0; i < 8; i++)
      step(1'b1, 3'(i), 32'h1000_0000 + 32'(i), 1'b0, 3'd0,
           4'd0, 1'b1, 1'b1, 1'b0, "pre");

    // Write then read the same register.
    step(1'b1, 3'd5, 32'hDEAD_BEEF, 1'b0, 3'd0, 4'd0,
         1'b1, 1'b1, 1'b0, "t2_wr");
    exp_q.push_back({32'hDEAD_BEEF, 4'd3});
    step(1'b0, 3'd0, 32'd0, 1'b1, 3'd5, 4'd3,
         1'b1, 1'b0, 1'b1, "t2_rd");
    idle("t2_idle");
    chk("t2_latency", {31'd0, rsp_valid}, 32'd1);
    idle("t2_idle2");

    // Starvation: 4 writes win, 5th cycle read, writes resume.
    for (int i = 0; i < 4; i++)
      step(1'b1, 3'd6, 32'h6666_6666, 1'b1, 3'd1, 4'd7,
           1'b1, 1'b1, 1'b0, "t3_wr");
    exp_q.push_back({32'h1000_0001, 4'd7});
    step(1'b1, 3'd6, 32'h6666_6666, 1'b1, 3'd1, 4'd7,
         1'b1, 1'b0, 1'b1, "t3_rd");
    step(1'b1, 3'd6, 32'h6666_6666, 1'b1, 3'd1, 4'd7,
         1'b1, 1'b1, 1'b0, "t3_resume");
    idle("t3_idle");
    idle("t3_idle2");

    // Backpressure: only two reads fit while rsp_ready=0.
    exp_q.push_back({32'h1000_0001, 4'd1});
    exp_q.push_back({32'h1000_0002, 4'd2});
    exp_q.push_back({32'h1000_0003, 4'd3});
    step(1'b0, 3'd0, 32'd0, 1'b1, 3'd1, 4'd1, 1'b0, 1'b0, 1'b1, "t4_a");
    step(1'b0, 3'd0, 32'd0, 1'b1, 3'd2, 4'd2, 1'b0, 1'b0, 1'b1, "t4_b");
    step(1'b0, 3'd0, 32'd0, 1'b1, 3'd3, 4'd3, 1'b0, 1'b0, 1'b0, "t4_c");
    step(1'b0, 3'd0, 32'd0, 1'b1, 3'd3, 4'd3, 1'b0, 1'b0, 1'b0, "t4_d");
    chk("t4_head_tag", {28'd0, rsp_tag}, 32'd1);
    step(1'b0, 3'd0, 32'd0, 1'b1, 3'd3, 4'd3, 1'b1, 1'b0, 1'b0, "t4_e");
    step(1'b0, 3'd0, 32'd0, 1'b1, 3'd3, 4'd3, 1'b1, 1'b0, 1'b1, "t4_f");
    idle("t4_idle");
    idle("t4_idle2");

    // Continuous reads with the consumer always ready.
    exp5[0] = 32'h1000_0000;
    exp5[1] = 32'h1000_0001;
    exp5[2] = 32'h1000_0002;
    exp5[3] = 32'h1000_0003;
    exp5[4] = 32'h1000_0004;
    exp5[5] = 32'hDEAD_BEEF;
    exp5[6] = 32'h6666_6666;
    exp5[7] = 32'h1000_0007;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({exp5[i], 4'(i)});
      step(1'b0, 3'd0, 32'd0, 1'b1, 3'(i), 4'(i),
           1'b1, 1'b0, 1'b1, "t5_rd");
      if (i > 0) chk("t5_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    end
    idle("t5_idle");
    chk("t5_last_valid", {31'd0, rsp_valid}, 32'd1);
    idle("t5_idle2");

    // Same-address write and read.
    exp_q.push_back({32'h0000_1234, 4'd9});
`ifdef RF_BANK_BYPASS_EN
    step(1'b1, 3'd7, 32'h0000_1234, 1'b1, 3'd7, 4'd9,
         1'b1, 1'b1, 1'b1, "t6_both");
    idle("t6_idle");
    chk("t6_valid", {31'd0, rsp_valid}, 32'd1);
`else
    step(1'b1, 3'd7, 32'h0000_1234, 1'b1, 3'd7, 4'd9,
         1'b1, 1'b1, 1'b0, "t6_wr");
    step(1'b0, 3'd7, 32'h0000_1234, 1'b1, 3'd7, 4'd9,
         1'b1, 1'b0, 1'b1, "t6_rd");
    idle("t6_idle");
    chk("t6_valid", {31'd0, rsp_valid}, 32'd1);
`endif
    idle("t6_idle2");

    // Reset with one buffered and one in-flight read: both dropped.
    step(1'b0, 3'd0, 32'd0, 1'b1, 3'd2, 4'd2, 1'b0, 1'b0, 1'b1, "t1_a");
    step(1'b0, 3'd0, 32'd0, 1'b1, 3'd3, 4'd3, 1'b0, 1'b0, 1'b1, "t1_b");
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    wb_valid = 1'b1;
    rd_valid = 1'b1;
    #1;
    chk("t1_wb_ready", {31'd0, wb_ready}, 32'd0);
    chk("t1_rd_ready", {31'd0, rd_ready}, 32'd0);
    chk("t1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    wb_valid  = 1'b0;
    rd_valid  = 1'b0;
    rsp_ready = 1'b1;
    rst_n     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle("t1_post");
      chk("t1_post_valid", {31'd0, rsp_valid}, 32'd0);
    end

    chk("q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
